// File: rtl/fifo_write_arbiter_pkg.sv
// Shared types and constants for the fifo write-port arbiter.
package fifo_write_arbiter_pkg;

    typedef enum logic {
        StIdle  = 1'b0,
        StGrant = 1'b1
    } arb_state_e;

    localparam int unsigned StallWidth = 16;

endpackage

// File: rtl/fifo_write_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid request after 'last', wrapping mod NUM_REQ.
module fifo_write_arbiter_rr_pick #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned ID_WIDTH = 2
) (
    input  logic [NUM_REQ-1:0]  req,
    input  logic [ID_WIDTH-1:0] last,
    output logic [ID_WIDTH-1:0] pick,
    output logic                any_valid
);

    // Walk from the farthest candidate to the nearest so the nearest valid one wins.
    always_comb begin
        int unsigned idx;
        pick      = '0;
        any_valid = 1'b0;
        idx       = 0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = 32'(last) + 32'(k);
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (req[idx[ID_WIDTH-1:0]]) begin
                pick      = idx[ID_WIDTH-1:0];
                any_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one fifo write port among NUM_REQ producers,
// with capped bursts, full-flag backpressure and a saturating stall counter.
module fifo_write_arbiter
    import fifo_write_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MAX_BURST  = 4,
    parameter int unsigned ID_WIDTH   = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_wr_data,
    output logic                          grant_valid,
    output logic [ID_WIDTH-1:0]           grant_id,
    output logic [15:0]                   stall_count
);

    localparam int unsigned BurstWidth = $clog2(MAX_BURST + 1);
    localparam logic [BurstWidth-1:0] BurstLast = BurstWidth'(MAX_BURST - 1);
    localparam logic [ID_WIDTH-1:0] LastReset = ID_WIDTH'(NUM_REQ - 1);

    arb_state_e              state_q, state_d;
    logic [ID_WIDTH-1:0]     grant_q, grant_d;
    logic [ID_WIDTH-1:0]     last_q, last_d;
    logic [BurstWidth-1:0]   burst_q, burst_d;
    logic [StallWidth-1:0]   stall_q, stall_d;

    logic [ID_WIDTH-1:0]     pick_last;
    logic [ID_WIDTH-1:0]     pick;
    logic                    any_valid;
    logic                    owner_valid;
    logic                    rotate;

    assign owner_valid = req_valid[grant_q];

    // While granted, a rotation searches past the current owner, which becomes last_grant.
    assign pick_last = (state_q == StGrant) ? grant_q : last_q;

    fifo_write_arbiter_rr_pick #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_rr_pick (
        .req       (req_valid),
        .last      (pick_last),
        .pick      (pick),
        .any_valid (any_valid)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            grant_q <= '0;
            last_q  <= LastReset;
            burst_q <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            burst_q <= burst_d;
            stall_q <= stall_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        burst_d = burst_q;
        stall_d = stall_q;
        rotate  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (any_valid) begin
                    state_d = StGrant;
                    grant_d = pick;
                    burst_d = '0;
                end
            end
            StGrant: begin
                if (owner_valid && fifo_full) begin
                    if (stall_q != '1) begin
                        stall_d = stall_q + 1'b1;
                    end
                end else if (owner_valid) begin
                    if (burst_q == BurstLast) begin
                        rotate = 1'b1;
                    end else begin
                        burst_d = burst_q + 1'b1;
                    end
                end else begin
                    rotate = 1'b1;
                end
                // The picker already sees the owner last, so it only wins back the grant
                // when no other producer is valid.
                if (rotate) begin
                    last_d  = grant_q;
                    burst_d = '0;
                    if (any_valid) begin
                        grant_d = pick;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        grant_valid = (state_q == StGrant);
        grant_id    = grant_q;
        fifo_wr_en  = grant_valid & owner_valid & ~fifo_full;
        // Data follows the owner whether or not it is valid; forced to zero when nobody owns it.
        fifo_wr_data = grant_valid ? req_data[32'(grant_q)*DATA_WIDTH +: DATA_WIDTH] : '0;
        req_ready   = '0;
        if (grant_valid && !fifo_full) begin
            req_ready[grant_q] = 1'b1;
        end
        stall_count = stall_q;
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Randomized and directed bench for fifo_write_arbiter against a queue-free behavioural model.
module tb_fifo_write_arbiter;

    localparam int NumReq    = 4;
    localparam int DataWidth = 8;
    localparam int MaxBurst  = 4;
    localparam int FifoDepth = 32;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_ready;
    logic        fifo_full = 1'b0;
    logic        fifo_wr_en;
    logic [7:0]  fifo_wr_data;
    logic        grant_valid;
    logic [1:0]  grant_id;
    logic [15:0] stall_count;

    fifo_write_arbiter #(
        .NUM_REQ    (NumReq),
        .DATA_WIDTH (DataWidth),
        .MAX_BURST  (MaxBurst),
        .ID_WIDTH   (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .fifo_full    (fifo_full),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .grant_valid  (grant_valid),
        .grant_id     (grant_id),
        .stall_count  (stall_count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] prod_data [NumReq];
    logic [3:0] cur_v;
    logic       cur_full;

    // Model state: owner index or -1, last owner, beats in current burst, stall cycles.
    int         m_owner;
    int         m_last;
    int         m_beats;
    int         m_stall;
    logic [3:0] m_xfer;
    int         fifo_occ;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int rr_next(input int last, input logic [3:0] v);
        for (int k = 1; k <= NumReq; k++) begin
            int i;
            i = (last + k) % NumReq;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_last  = NumReq - 1;
        m_beats = 0;
        m_stall = 0;
        m_xfer  = '0;
    endtask

    task automatic model_step(input logic [3:0] v, input logic full);
        bit done;
        m_xfer = '0;
        if (m_owner < 0) begin
            m_owner = rr_next(m_last, v);
            m_beats = 0;
        end else if (v[m_owner] && full) begin
            if (m_stall < 65535) m_stall++;
        end else begin
            done = !v[m_owner];
            if (!done) begin
                m_xfer[m_owner] = 1'b1;
                m_beats++;
                done = (m_beats == MaxBurst);
            end
            if (done) begin
                m_last  = m_owner;
                m_beats = 0;
                m_owner = rr_next(m_last, v);
            end
        end
    endtask

    task automatic drive(input logic [3:0] v, input logic full);
        cur_v     = v;
        cur_full  = full;
        req_valid = v;
        fifo_full = full;
        for (int i = 0; i < NumReq; i++) req_data[i*DataWidth +: DataWidth] = prod_data[i];
    endtask

    task automatic compare_outputs();
        logic       exp_gv;
        logic       exp_wr;
        logic [7:0] exp_data;
        logic [3:0] exp_rdy;
        exp_gv   = (m_owner >= 0);
        exp_wr   = exp_gv && cur_v[m_owner] && !cur_full;
        exp_data = exp_gv ? prod_data[m_owner] : 8'h00;
        exp_rdy  = (exp_gv && !cur_full) ? (4'b0001 << m_owner) : 4'b0000;
        check("grant_valid", 32'(grant_valid), 32'(exp_gv));
        if (exp_gv) check("grant_id", 32'(grant_id), 32'(m_owner));
        check("fifo_wr_en", 32'(fifo_wr_en), 32'(exp_wr));
        check("fifo_wr_data", 32'(fifo_wr_data), 32'(exp_data));
        check("req_ready", 32'(req_ready), 32'(exp_rdy));
        check("stall_count", 32'(stall_count), 32'(m_stall));
    endtask

    task automatic run_cycle(input logic [3:0] v, input logic full);
        @(negedge clk);
        drive(v, full);
        #1 compare_outputs();
        @(posedge clk);
        model_step(cur_v, cur_full);
        if (m_xfer != 0) fifo_occ++;
        for (int i = 0; i < NumReq; i++) begin
            if (m_xfer[i]) prod_data[i] = 8'($urandom);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_grant_valid"}, 32'(grant_valid), 32'h0);
        check({tag, "_grant_id"}, 32'(grant_id), 32'h0);
        check({tag, "_wr_en"}, 32'(fifo_wr_en), 32'h0);
        check({tag, "_wr_data"}, 32'(fifo_wr_data), 32'h0);
        check({tag, "_ready"}, 32'(req_ready), 32'h0);
        check({tag, "_stall"}, 32'(stall_count), 32'h0);
    endtask

    // Asserts reset between edges, checks outputs clear without a clock, holds across one
    // edge, then releases just after a rising edge so the model and DUT stay aligned.
    task automatic reset_dut(input string tag);
        reset = 1'b1;
        #1 check_reset_outputs({tag, "_async"});
        @(posedge clk);
        #1 check_reset_outputs({tag, "_held"});
        model_reset();
        fifo_occ = 0;
        reset = 1'b0;
    endtask

    initial begin
        int         s_before;
        logic [3:0] v;
        logic       full;

        for (int i = 0; i < NumReq; i++) prod_data[i] = 8'($urandom);
        model_reset();
        fifo_occ = 0;
        drive(4'b0000, 1'b0);

        // Reset and first request on producer 2.
        #2 reset_dut("rst0");
        run_cycle(4'b0000, 1'b0);
        run_cycle(4'b0100, 1'b0);
        run_cycle(4'b0100, 1'b0);
        run_cycle(4'b0000, 1'b0);

        // All producers streaming: 4-beat bursts in rotation with no idle cycles.
        for (int c = 0; c < 20; c++) run_cycle(4'b1111, 1'b0);

        // Lone producer 1 keeps the grant across burst boundaries.
        reset_dut("rst1");
        for (int c = 0; c < 12; c++) run_cycle(4'b0010, 1'b0);

        // Owner 3 stalled 5 cycles at burst_cnt=2, then finishes 2 beats and rotates to 0.
        reset_dut("rst2");
        run_cycle(4'b1000, 1'b0);
        run_cycle(4'b1000, 1'b0);
        run_cycle(4'b1000, 1'b0);
        #1 s_before = int'(stall_count);
        for (int c = 0; c < 5; c++) run_cycle(4'b1000, 1'b1);
        #1 check("stall_delta", 32'(int'(stall_count) - s_before), 32'd5);
        for (int c = 0; c < 4; c++) run_cycle(4'b1001, 1'b0);

        // Owner 0 drops after one beat; producer 2 takes over, skipping invalid producer 1.
        reset_dut("rst3");
        run_cycle(4'b0101, 1'b0);
        run_cycle(4'b0101, 1'b0);
        run_cycle(4'b0100, 1'b0);
        run_cycle(4'b0100, 1'b0);

        // Reset mid-burst, then arbitration restarts from producer 0.
        for (int c = 0; c < 6; c++) run_cycle(4'b1111, 1'b0);
        drive(4'b1111, 1'b0);
        #2 reset_dut("rst4");
        run_cycle(4'b1111, 1'b0);
        run_cycle(4'b1111, 1'b0);

        // Randomized traffic with a depth-32 fifo drained at a slower rate than it fills.
        reset_dut("rst5");
        v = '0;
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < NumReq; i++) begin
                if (cur_v[i] && !m_xfer[i]) v[i] = ($urandom_range(15) != 0);
                else v[i] = 1'($urandom_range(1));
            end
            if (fifo_occ > 0 && $urandom_range(2) == 0) fifo_occ--;
            if (c > 600 && fifo_occ > 0) fifo_occ--;
            full = (fifo_occ >= FifoDepth);
            run_cycle(v, full);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
